// File: rtl/uart_tx_cfg.sv
// AXI4-Stream UART transmitter with run-time parity and stop-bit selection.
// One word per frame, LSB first; bit period is 8*max(prescale,1) clocks.
module uart_tx_cfg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done,
    input  logic [15:0]           prescale,
    input  logic [1:0]            parity_mode,
    input  logic                  two_stop
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_data;
    logic [18:0]           r_period;
    logic [18:0]           r_cnt;
    logic [18:0]           w_cnt_next;
    logic [3:0]            r_bit_idx;
    logic [3:0]            w_bit_idx_next;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_two_stop;
    logic                  r_ready;
    logic                  w_load;
    logic                  w_bit_end;
    logic                  w_txd;
    logic                  w_done;
    logic                  w_parity;
    logic [15:0]           w_ps;
    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_ps      = (prescale == 16'd0) ? 16'd1 : prescale;
    assign w_parity  = (parity_mode == 2'b01) ? ~^s_axis_tdata :
                       (parity_mode == 2'b10) ?  ^s_axis_tdata : 1'b1;
    assign w_bit_end = (r_cnt == r_period - 19'd1);
    assign w_shifted = r_data >> r_bit_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_ready    <= 1'b0;
            r_data     <= '0;
            r_period   <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_ready   <= (w_state_next == S_IDLE);
            // Frame configuration is frozen at the handshake.
            if (w_load) begin
                r_data     <= s_axis_tdata;
                r_period   <= {w_ps, 3'b000};
                r_par_en   <= (parity_mode != 2'b00);
                r_par_bit  <= w_parity;
                r_two_stop <= two_stop;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt + 19'd1;
        w_bit_idx_next = r_bit_idx;
        w_load         = 1'b0;
        w_txd          = 1'b1;
        w_done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (s_axis_tvalid && r_ready) begin
                    w_load         = 1'b1;
                    w_state_next   = S_START;
                    w_bit_idx_next = '0;
                end
            end
            S_START: begin
                w_txd = 1'b0;
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_txd = w_shifted[0];
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_bit_idx == 4'(DATA_WIDTH - 1)) begin
                        w_bit_idx_next = '0;
                        w_state_next   = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                w_txd = r_par_bit;
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                // r_bit_idx counts completed stop bits here.
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_two_stop && (r_bit_idx == 4'd0)) begin
                        w_bit_idx_next = 4'd1;
                    end else begin
                        w_bit_idx_next = '0;
                        w_done         = 1'b1;
                        w_state_next   = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign s_axis_tready = r_ready;
    assign txd           = w_txd;
    assign busy          = (r_state != S_IDLE);
    assign tx_done       = w_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: 8-bit and 7-bit builds, directed and
// random frames compared cycle by cycle against a bit-list frame model.
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  tdata8;
    logic [6:0]  tdata7;
    logic        valid8, valid7;
    logic [15:0] prescale;
    logic [1:0]  pm;
    logic        ts;
    logic        rdy8, txd8, busy8, done8;
    logic        rdy7, txd7, busy7, done7;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_cfg #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata8), .s_axis_tvalid(valid8),
        .s_axis_tready(rdy8), .txd(txd8), .busy(busy8), .tx_done(done8),
        .prescale(prescale), .parity_mode(pm), .two_stop(ts)
    );

    uart_tx_cfg #(.DATA_WIDTH(7)) dut7 (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata7), .s_axis_tvalid(valid7),
        .s_axis_tready(rdy7), .txd(txd7), .busy(busy7), .tx_done(done7),
        .prescale(prescale), .parity_mode(pm), .two_stop(ts)
    );

    function automatic logic g_txd(int s);  return (s == 1) ? txd7  : txd8;  endfunction
    function automatic logic g_busy(int s); return (s == 1) ? busy7 : busy8; endfunction
    function automatic logic g_rdy(int s);  return (s == 1) ? rdy7  : rdy8;  endfunction
    function automatic logic g_done(int s); return (s == 1) ? done7 : done8; endfunction

    task automatic chk(string tag, logic obs, logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(string tag, int obs, int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(int s, logic [8:0] d, logic [15:0] p, logic [1:0] m, logic t);
        tdata8   = d[7:0];
        tdata7   = d[6:0];
        prescale = p;
        pm       = m;
        ts       = t;
    endtask

    // Sends one frame on instance s and checks every cycle of it. At frame cycle 2
    // the inputs are switched to the "next" values; hold keeps tvalid asserted.
    task automatic send(int s, logic [8:0] d, logic [15:0] p, logic [1:0] m, logic t,
                        logic hold, logic [8:0] nd, logic [15:0] np, logic [1:0] nm,
                        logic nt, output int k_start);
        int dw, tb, pop, guard, total;
        bit bits[$];
        dw = (s == 1) ? 7 : 8;
        tb = 8 * ((p == 16'd0) ? 1 : int'(p));
        pop = 0;
        for (int i = 0; i < dw; i++) pop += int'(d[i]);
        bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) bits.push_back(d[i]);
        if (m == 2'b01) bits.push_back((pop % 2) == 0);
        if (m == 2'b10) bits.push_back((pop % 2) == 1);
        if (m == 2'b11) bits.push_back(1'b1);
        bits.push_back(1'b1);
        if (t) bits.push_back(1'b1);
        total = bits.size() * tb;
        k_start = 0;

        drive(s, d, p, m, t);
        valid8 = (s == 0);
        valid7 = (s == 1);
        guard = 0;
        while (!g_rdy(s) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk_int("handshake_in_time", int'(guard < 2000), 1);
        if (guard >= 2000) return;
        @(posedge clk);
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            if (c == 1) begin
                k_start = cyc;
                if (!hold) begin
                    valid8 = 1'b0;
                    valid7 = 1'b0;
                end
            end
            if (c == 2) drive(s, nd, np, nm, nt);
            chk("txd_bit", g_txd(s), bits[(c - 1) / tb]);
            chk("busy_frame", g_busy(s), 1'b1);
            chk("tready_frame", g_rdy(s), 1'b0);
            chk("tx_done", g_done(s), (c == total));
        end
        @(negedge clk);
        chk("txd_idle", g_txd(s), 1'b1);
        chk("busy_idle", g_busy(s), 1'b0);
        chk("tready_idle", g_rdy(s), 1'b1);
        chk("done_idle", g_done(s), 1'b0);
        $display("frame dut%0d data=%h prescale=%0d parity=%0d two_stop=%0b cycles=%0d",
                 (s == 1) ? 7 : 8, d, p, m, t, total);
    endtask

    initial begin
        int k1, k2, kx, s;
        logic [8:0]  rd;
        logic [15:0] rp;
        logic [1:0]  rm;
        logic        rt;
        rst = 1'b1;
        valid8 = 1'b0;
        valid7 = 1'b0;
        drive(0, 9'h0, 16'd1, 2'b00, 1'b0);
        #1;
        chk("rst_txd", txd8, 1'b1);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_tready", rdy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        chk("rst_txd7", txd7, 1'b1);
        chk("rst_tready7", rdy7, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tready", rdy8, 1'b1);

        send(0, 9'h55, 16'd1, 2'b00, 1'b0, 1'b0, 9'h55, 16'd1, 2'b00, 1'b0, kx);
        send(0, 9'h55, 16'd2, 2'b10, 1'b0, 1'b0, 9'h55, 16'd2, 2'b10, 1'b0, kx);
        send(0, 9'h55, 16'd2, 2'b01, 1'b0, 1'b0, 9'h55, 16'd2, 2'b01, 1'b0, kx);
        send(1, 9'h7F, 16'd0, 2'b11, 1'b1, 1'b0, 9'h7F, 16'd0, 2'b11, 1'b1, kx);

        // Back-to-back with tvalid held, then a mid-frame config change.
        send(0, 9'hA5, 16'd1, 2'b00, 1'b0, 1'b1, 9'h3C, 16'd1, 2'b00, 1'b0, k1);
        send(0, 9'h3C, 16'd1, 2'b00, 1'b0, 1'b0, 9'h12, 16'd3, 2'b10, 1'b1, k2);
        chk_int("b2b_start_gap", k2 - k1, 81);
        send(0, 9'h12, 16'd3, 2'b10, 1'b1, 1'b0, 9'h12, 16'd3, 2'b10, 1'b1, kx);

        // Reset during a data bit abandons the frame.
        drive(0, 9'h00, 16'd1, 2'b00, 1'b0);
        valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid8 = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_busy", busy8, 1'b1);
        chk("mid_txd_data0", txd8, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_txd", txd8, 1'b1);
        chk("arst_busy", busy8, 1'b0);
        chk("arst_tready", rdy8, 1'b0);
        chk("arst_done", done8, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("rel_tready_before_clk", rdy8, 1'b0);
        @(negedge clk);
        chk("rel_tready", rdy8, 1'b1);
        chk("rel_done", done8, 1'b0);
        chk("rel_txd", txd8, 1'b1);
        $display("reset mid-frame applied");
        send(0, 9'hC3, 16'd1, 2'b01, 1'b1, 1'b0, 9'hC3, 16'd1, 2'b01, 1'b1, kx);

        for (int i = 0; i < 12; i++) begin
            s  = int'($urandom_range(0, 1));
            rd = 9'($urandom);
            rp = 16'($urandom_range(0, 3));
            rm = 2'($urandom_range(0, 3));
            rt = 1'($urandom_range(0, 1));
            send(s, rd, rp, rm, rt, 1'b0, rd, rp, rm, rt, kx);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
